// File: rtl/seg7_pkg.sv
// seg7_pkg: constants and the hex decode helper shared by the 7-segment scan
// driver and its nibble decoder.
//   SEG_BLANK      - all segments off (active-low), dp included
//   HEX_SEG_TABLE  - 16-entry nibble -> {g,f,e,d,c,b,a} pattern, active-low
//   hex2seg()      - table lookup wrapper
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Patterns for 0..9, A, b, C, d, E, F with bit 0 = segment a.
  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
    return HEX_SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// hex_to_seg7: purely combinational nibble to 7-segment decoder.
// Ports:
//   nibble  in   4  hex digit value
//   seg     out  7  active-low segment pattern {g,f,e,d,c,b,a}
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex2seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a common-anode multi-digit
// 7-segment display. Incoming display data is double-buffered so a new value
// only becomes visible at a frame boundary (digit 0), avoiding tearing.
//
// Optional feature macro: SEG7_BLINK_EN
//   defined   - digits flagged in blink_mask are blanked every other
//               BLINK_FRAMES-frame period
//   undefined - blink_mask is still buffered but has no effect
//
// Ports:
//   clk          in   1             system clock
//   rst          in   1             synchronous, active-high reset
//   load         in   1             strobe: capture hex_data/point/blink_mask
//   hex_data     in   4*NUM_DIGITS  nibble k drives digit k (0 = rightmost)
//   point        in   NUM_DIGITS    decimal point enable per digit
//   blink_mask   in   NUM_DIGITS    blink enable per digit
//   an           out  NUM_DIGITS    anode select, active-low, one-cold
//   seg          out  8             segments {dp,g,f,e,d,c,b,a}, active-low
//   frame_start  out  1             pulse when digit 0 becomes active
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] hex_data,
  input  logic [NUM_DIGITS-1:0]   point,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg,
  output logic                    frame_start
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CNT_W-1:0]        prescale;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_next;
  logic                    tick;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] pend_hex;
  logic [NUM_DIGITS-1:0]   pend_point;
  logic [NUM_DIGITS-1:0]   pend_blink;
  logic                    pend_valid;

  logic [4*NUM_DIGITS-1:0] act_hex;
  logic [NUM_DIGITS-1:0]   act_point;
  logic [NUM_DIGITS-1:0]   act_blink;
  logic [4*NUM_DIGITS-1:0] act_hex_next;
  logic [NUM_DIGITS-1:0]   act_point_next;
  logic [NUM_DIGITS-1:0]   act_blink_next;

  logic                    blank_next;
  logic [3:0]              nibble_next;
  logic [6:0]              seg_digit;

  assign tick     = (prescale == CNT_W'(SCAN_DIV - 1));
  assign wrap     = tick && (idx == IDX_W'(NUM_DIGITS - 1));
  assign idx_next = wrap ? '0 : idx + 1'b1;

  // Prescaler and digit index; the index only moves on a slot tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale <= '0;
      idx      <= '0;
    end else begin
      prescale <= tick ? '0 : prescale + 1'b1;
      if (tick) begin
        idx <= idx_next;
      end
    end
  end

  // Frame-boundary swap. A load coinciding with the wrap bypasses the
  // pending buffer so the new data shows without a one-frame delay.
  always_comb begin
    act_hex_next   = act_hex;
    act_point_next = act_point;
    act_blink_next = act_blink;
    if (wrap) begin
      if (load) begin
        act_hex_next   = hex_data;
        act_point_next = point;
        act_blink_next = blink_mask;
      end else if (pend_valid) begin
        act_hex_next   = pend_hex;
        act_point_next = pend_point;
        act_blink_next = pend_blink;
      end
    end
  end

  // Pending and active buffers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_hex   <= '0;
      pend_point <= '0;
      pend_blink <= '0;
      pend_valid <= 1'b0;
      act_hex    <= '0;
      act_point  <= '0;
      act_blink  <= '0;
    end else begin
      act_hex   <= act_hex_next;
      act_point <= act_point_next;
      act_blink <= act_blink_next;
      if (load && !wrap) begin
        pend_hex   <= hex_data;
        pend_point <= point;
        pend_blink <= blink_mask;
        pend_valid <= 1'b1;
      end else if (wrap) begin
        pend_valid <= 1'b0;
      end
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BF_W-1:0] blink_cnt;
  logic            blink_phase;
  logic            blink_phase_next;
  logic            blink_last;

  assign blink_last = (blink_cnt == BF_W'(BLINK_FRAMES - 1));

  // Phase seen by the digit being switched in, so blanking lines up with
  // the frame that the wrap starts.
  always_comb begin
    blink_phase_next = blink_phase;
    if (wrap && blink_last) begin
      blink_phase_next = ~blink_phase;
    end
  end

  // Frame counter for the blink half-period.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (wrap) begin
      blink_cnt   <= blink_last ? '0 : blink_cnt + 1'b1;
      blink_phase <= blink_phase_next;
    end
  end

  assign blank_next = blink_phase_next && act_blink_next[idx_next];
`else
  localparam int UNUSED_BLINK_FRAMES = BLINK_FRAMES;
  logic unused_blink;

  assign unused_blink = ^act_blink;
  assign blank_next   = 1'b0;
`endif

  assign nibble_next = act_hex_next[idx_next*4 +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble_next),
    .seg    (seg_digit)
  );

  // Output registers load on the tick edge from the next index/buffer
  // values, so they change together with the index. Until the first tick
  // they hold the blank reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      an          <= '1;
      seg         <= SEG_BLANK;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (tick) begin
        an  <= blank_next ? '1 : ~(NUM_DIGITS'(1) << idx_next);
        seg <= {~act_point_next[idx_next], seg_digit};
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized self-checking bench for seg7_scan_driver
// (NUM_DIGITS=8, SCAN_DIV=4, BLINK_FRAMES=2). The reference model counts
// clock edges since reset and snapshots the most recently loaded data at
// every frame boundary; display state is derived from those with plain
// arithmetic. Honors SEG7_BLINK_EN the same way the design does.
module tb_seg7_scan_driver;

  localparam int N     = 8;
  localparam int D     = 4;
  localparam int BF    = 2;
  localparam int FRAME = N * D;

  localparam logic [7:0] HEX_TAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] hex_data;
  logic [7:0]  point;
  logic [7:0]  blink_mask;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          n_edges;
  logic [31:0] lat_hex, shown_hex;
  logic [7:0]  lat_pt, shown_pt, lat_bl, shown_bl;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS   (N),
    .SCAN_DIV     (D),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .hex_data    (hex_data),
    .point       (point),
    .blink_mask  (blink_mask),
    .an          (an),
    .seg         (seg),
    .frame_start (frame_start)
  );

  // Drive one cycle of inputs, advance one edge, then update the model.
  task automatic step(input logic r, input logic ld, input logic [31:0] h,
                      input logic [7:0] p, input logic [7:0] b);
    rst = r; load = ld; hex_data = h; point = p; blink_mask = b;
    @(posedge clk);
    #1;
    if (r) begin
      n_edges = 0;
      lat_hex = '0; lat_pt = '0; lat_bl = '0;
      shown_hex = '0; shown_pt = '0; shown_bl = '0;
    end else begin
      n_edges++;
      if (ld) begin
        lat_hex = h; lat_pt = p; lat_bl = b;
      end
      if (n_edges % FRAME == 0) begin
        shown_hex = lat_hex; shown_pt = lat_pt; shown_bl = lat_bl;
      end
    end
    rst = 1'b0;
    load = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, $urandom, 8'($urandom), 8'($urandom));
  endtask

  function automatic logic [7:0] exp_an();
    int t = n_edges / D;
    int d = t % N;
    int f = t / N;
    if (t == 0) return 8'hFF;
`ifdef SEG7_BLINK_EN
    if (((f / BF) % 2) == 1 && shown_bl[d]) return 8'hFF;
`else
    if (f < 0) return 8'h00;
`endif
    return ~(8'd1 << d);
  endfunction

  function automatic logic [7:0] exp_seg();
    int t = n_edges / D;
    int d = t % N;
    logic [7:0] pat;
    if (t == 0) return 8'hFF;
    pat = HEX_TAB[shown_hex[4*d +: 4]];
    return {~shown_pt[d], pat[6:0]};
  endfunction

  function automatic logic exp_fs();
    return (n_edges > 0) && (n_edges % FRAME == 0);
  endfunction

  function automatic int cur_digit();
    return (n_edges / D) % N;
  endfunction

  task automatic test_reset();
    step(1'b1, 1'b0, 32'hDEADBEEF, 8'hFF, 8'hFF);
    step(1'b1, 1'b1, 32'h12345678, 8'hFF, 8'hFF);
    checks++;
    if (an !== 8'hFF) begin errors++; $display("[TB] FAIL reset_an got=%h want=ff", an); end
    checks++;
    if (seg !== 8'hFF) begin errors++; $display("[TB] FAIL reset_seg got=%h want=ff", seg); end
    checks++;
    if (frame_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_fs got=%b want=0", frame_start); end
    for (int i = 0; i < D - 1; i++) begin
      idle();
      checks++;
      if (an !== 8'hFF) begin errors++; $display("[TB] FAIL pre_tick_an i=%0d got=%h want=ff", i, an); end
    end
  endtask

  task automatic test_scan_basic();
    step(1'b0, 1'b1, 32'h76543210, 8'h00, 8'h00);
    while (n_edges < 3 * FRAME) begin
      idle();
      checks++;
      if (an !== exp_an()) begin errors++; $display("[TB] FAIL scan_an n=%0d got=%h want=%h", n_edges, an, exp_an()); end
      checks++;
      if (seg !== exp_seg()) begin errors++; $display("[TB] FAIL scan_seg n=%0d got=%h want=%h", n_edges, seg, exp_seg()); end
      checks++;
      if (frame_start !== exp_fs()) begin errors++; $display("[TB] FAIL scan_fs n=%0d got=%b want=%b", n_edges, frame_start, exp_fs()); end
    end
  endtask

  task automatic test_midframe_load();
    for (int i = 0; i < FRAME && !(cur_digit() == 3 && n_edges % D == 1); i++) idle();
    step(1'b0, 1'b1, 32'hFFFFFFFF, 8'h00, 8'h00);
    for (int i = 0; i < 2 * FRAME; i++) begin
      idle();
      checks++;
      if (an !== exp_an()) begin errors++; $display("[TB] FAIL mid_an n=%0d got=%h want=%h", n_edges, an, exp_an()); end
      checks++;
      if (seg !== exp_seg()) begin errors++; $display("[TB] FAIL mid_seg n=%0d got=%h want=%h", n_edges, seg, exp_seg()); end
    end
    checks++;
    if (shown_hex !== 32'hFFFFFFFF || seg !== 8'h8E) begin errors++; $display("[TB] FAIL mid_final_seg got=%h want=8e", seg); end
  endtask

  task automatic test_wrap_load();
    for (int i = 0; i < FRAME && ((n_edges + 1) % FRAME != 0); i++) idle();
    step(1'b0, 1'b1, 32'h88888888, 8'h00, 8'h00);
    checks++;
    if (seg !== 8'h80) begin errors++; $display("[TB] FAIL wrap_seg got=%h want=80", seg); end
    checks++;
    if (an !== 8'hFE) begin errors++; $display("[TB] FAIL wrap_an got=%h want=fe", an); end
    checks++;
    if (frame_start !== 1'b1) begin errors++; $display("[TB] FAIL wrap_fs got=%b want=1", frame_start); end
    for (int i = 0; i < FRAME; i++) begin
      idle();
      checks++;
      if (seg !== exp_seg()) begin errors++; $display("[TB] FAIL wrap_run_seg n=%0d got=%h want=%h", n_edges, seg, exp_seg()); end
    end
  endtask

  task automatic test_point();
    step(1'b0, 1'b1, 32'h00000000, 8'h01, 8'h00);
    for (int i = 0; i < 2 * FRAME; i++) begin
      idle();
      checks++;
      if (seg !== exp_seg()) begin errors++; $display("[TB] FAIL point_seg n=%0d got=%h want=%h", n_edges, seg, exp_seg()); end
      if (n_edges % FRAME == 0) begin
        checks++;
        if (seg !== 8'h40) begin errors++; $display("[TB] FAIL point_d0 got=%h want=40", seg); end
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b1, 32'hABCDEF12, 8'h5A, 8'h00);
    for (int i = 0; i < 2 * FRAME && !(n_edges >= FRAME && cur_digit() == 5); i++) idle();
    step(1'b1, 1'b0, 32'h0, 8'h0, 8'h0);
    checks++;
    if (an !== 8'hFF || seg !== 8'hFF) begin errors++; $display("[TB] FAIL rst_mid got an=%h seg=%h want ff ff", an, seg); end
    for (int i = 0; i < FRAME + FRAME / 2; i++) begin
      idle();
      checks++;
      if (an !== exp_an()) begin errors++; $display("[TB] FAIL rst_mid_an n=%0d got=%h want=%h", n_edges, an, exp_an()); end
      checks++;
      if (seg !== exp_seg()) begin errors++; $display("[TB] FAIL rst_mid_seg n=%0d got=%h want=%h", n_edges, seg, exp_seg()); end
    end
  endtask

  task automatic test_blink();
    step(1'b1, 1'b0, 32'h0, 8'h0, 8'h0);
    step(1'b0, 1'b1, 32'h12345678, 8'h00, 8'h02);
    while (n_edges < 6 * FRAME) begin
      idle();
      checks++;
      if (an !== exp_an()) begin errors++; $display("[TB] FAIL blink_an n=%0d got=%h want=%h", n_edges, an, exp_an()); end
      checks++;
      if (seg !== exp_seg()) begin errors++; $display("[TB] FAIL blink_seg n=%0d got=%h want=%h", n_edges, seg, exp_seg()); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'b0, ($urandom_range(0, 7) == 0), $urandom, 8'($urandom), 8'($urandom));
      checks++;
      if (an !== exp_an()) begin errors++; $display("[TB] FAIL rand_an n=%0d got=%h want=%h", n_edges, an, exp_an()); end
      checks++;
      if (seg !== exp_seg()) begin errors++; $display("[TB] FAIL rand_seg n=%0d got=%h want=%h", n_edges, seg, exp_seg()); end
      checks++;
      if (frame_start !== exp_fs()) begin errors++; $display("[TB] FAIL rand_fs n=%0d got=%b want=%b", n_edges, frame_start, exp_fs()); end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; hex_data = '0; point = '0; blink_mask = '0;
    n_edges = 0;
    lat_hex = '0; lat_pt = '0; lat_bl = '0;
    shown_hex = '0; shown_pt = '0; shown_bl = '0;
    test_reset();
    test_scan_basic();
    test_midframe_load();
    test_wrap_load();
    test_point();
    test_reset_mid();
    test_blink();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
